// File: rtl/aurras_pkg.sv
// Shared types and constants for the aurras room-measurement blocks.
// Sequencer state codes are visible on state_out and must not be renumbered.
package aurras_pkg;

  localparam int unsigned AUDIO_RATE   = 48000;
  localparam int unsigned LINE_SAMPLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CLICK  = 3'd2,
    ST_RECORD = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } meas_state_t;

  function automatic logic state_is_busy(input meas_state_t s);
    return (s == ST_SETTLE) || (s == ST_CLICK) || (s == ST_RECORD);
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: one register of history plus AND-NOT.
// The input must already be synchronous to clk.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic edge_o
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end

  assign edge_o = d_i & ~d_q;

endmodule

// File: rtl/impulse_measure_sequencer.sv
// Sequences one room-impulse measurement: settle, click + recorder start,
// count recorded memory lines, then enable the convolver (or flag a timeout).
module impulse_measure_sequencer
  import aurras_pkg::*;
#(
  parameter int unsigned        SETTLE_SAMPLES  = 4800,
  parameter int unsigned        CLICK_SAMPLES   = 4,
  parameter logic signed [15:0] CLICK_AMPLITUDE = 16'sh7000,
  parameter int unsigned        IMPULSE_LINES   = 750,
  parameter int unsigned        TIMEOUT_SAMPLES = 96000
) (
  input  logic               audio_clk,
  input  logic               rst_in_n,
  input  logic               audio_trigger,
  input  logic               start_in,
  input  logic               abort_in,
  input  logic               line_written_in,
  input  logic               impulse_recorded_in,
  output logic signed [15:0] click_out,
  output logic               click_active_out,
  output logic               record_trigger_out,
  output logic               convolve_enable_out,
  output logic               busy_out,
  output logic               fault_out,
  output logic [2:0]         state_out
);

  localparam logic [16:0] SETTLE_LAST   = 17'(SETTLE_SAMPLES - 1);
  localparam logic [16:0] CLICK_LAST    = 17'(CLICK_SAMPLES - 1);
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_SAMPLES);
  localparam logic [16:0] SAMPLE_MAX    = '1;
  localparam logic [9:0]  LINE_LIMIT    = 10'(IMPULSE_LINES);

  meas_state_t        state_q, state_d;
  logic [16:0]        sample_cnt_q, sample_cnt_d, sample_inc;
  logic [9:0]         line_cnt_q, line_cnt_d, line_inc;
  logic               start_q, start_edge;
  logic               rec_trig_d;
  logic signed [15:0] click_q;
  logic               click_active_q, rec_trig_q, conv_q, busy_q, fault_q;

  // The start button is registered before edge detection, so start-to-SETTLE is two clocks.
  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) start_q <= 1'b0;
    else           start_q <= start_in;
  end

  rise_edge_detect u_start_edge (
    .clk    (audio_clk),
    .rst_n  (rst_in_n),
    .d_i    (start_q),
    .edge_o (start_edge)
  );

  assign sample_inc = (sample_cnt_q == SAMPLE_MAX) ? sample_cnt_q : sample_cnt_q + 17'd1;
  assign line_inc   = (line_cnt_q >= LINE_LIMIT)   ? line_cnt_q   : line_cnt_q + 10'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    line_cnt_d   = line_cnt_q;
    rec_trig_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start_edge) begin
        state_d      = ST_SETTLE;
        sample_cnt_d = '0;
      end
      ST_SETTLE: if (audio_trigger) begin
        if (sample_cnt_q == SETTLE_LAST) begin
          state_d      = ST_CLICK;
          sample_cnt_d = '0;
          rec_trig_d   = 1'b1;
        end else begin
          sample_cnt_d = sample_inc;
        end
      end
      ST_CLICK: if (audio_trigger) begin
        if (sample_cnt_q == CLICK_LAST) begin
          state_d      = ST_RECORD;
          sample_cnt_d = '0;
          line_cnt_d   = '0;
        end else begin
          sample_cnt_d = sample_inc;
        end
      end
      ST_RECORD: begin
        if (audio_trigger)   sample_cnt_d = sample_inc;
        if (line_written_in) line_cnt_d   = line_inc;
        // Completion is tested first so it wins over a same-cycle timeout.
        if (line_cnt_d == LINE_LIMIT || impulse_recorded_in) state_d = ST_DONE;
        else if (sample_cnt_d >= TIMEOUT_LIMIT)              state_d = ST_FAULT;
      end
      ST_DONE, ST_FAULT: if (start_edge) begin
        state_d      = ST_SETTLE;
        sample_cnt_d = '0;
        line_cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_in) begin
      state_d      = ST_IDLE;
      sample_cnt_d = '0;
      line_cnt_d   = '0;
      rec_trig_d   = 1'b0;
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q        <= ST_IDLE;
      sample_cnt_q   <= '0;
      line_cnt_q     <= '0;
      click_q        <= '0;
      click_active_q <= 1'b0;
      rec_trig_q     <= 1'b0;
      conv_q         <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      line_cnt_q     <= line_cnt_d;
      click_q        <= (state_d == ST_CLICK) ? CLICK_AMPLITUDE : 16'sd0;
      click_active_q <= (state_d == ST_CLICK);
      rec_trig_q     <= rec_trig_d;
      conv_q         <= (state_d == ST_DONE);
      busy_q         <= state_is_busy(state_d);
      fault_q        <= (state_d == ST_FAULT);
    end
  end

  assign click_out           = click_q;
  assign click_active_out    = click_active_q;
  assign record_trigger_out  = rec_trig_q;
  assign convolve_enable_out = conv_q;
  assign busy_out            = busy_q;
  assign fault_out           = fault_q;
  assign state_out           = state_q;

endmodule
